// File: rtl/vending_pkg.sv
// Shared types and constants for the vending credit path.
// State encoding, coin weights, credit width and the coin-sum helper.
package vending_pkg;

    localparam int CREDIT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    localparam logic [CREDIT_W:0] COIN_W0 = 9'd1;
    localparam logic [CREDIT_W:0] COIN_W1 = 9'd2;
    localparam logic [CREDIT_W:0] COIN_W2 = 9'd5;
    localparam logic [CREDIT_W:0] COIN_W3 = 9'd10;

    // Weighted sum of all coins seen in one cycle (max 18).
    function automatic logic [CREDIT_W:0] coin_sum(input logic [3:0] c);
        logic [CREDIT_W:0] s;
        s = '0;
        if (c[0]) s = s + COIN_W0;
        if (c[1]) s = s + COIN_W1;
        if (c[2]) s = s + COIN_W2;
        if (c[3]) s = s + COIN_W3;
        return s;
    endfunction

endpackage

// File: rtl/price_table.sv
// Product price lookup, parameterised per product.
// Ports: product_id (2b) in, price (8b) out.
module price_table #(
    parameter int PRICE0 = 15,
    parameter int PRICE1 = 25,
    parameter int PRICE2 = 40,
    parameter int PRICE3 = 60
) (
    input  logic [1:0] product_id,
    output logic [7:0] price
);

    always_comb begin
        price = 8'(PRICE0);
        unique case (product_id)
            2'd0: price = 8'(PRICE0);
            2'd1: price = 8'(PRICE1);
            2'd2: price = 8'(PRICE2);
            2'd3: price = 8'(PRICE3);
        endcase
    end

endmodule

// File: rtl/credit_accumulator.sv
// Vending credit accumulator: coins in, purchase/refund via handshakes.
// Ports: coin/select/cancel pulses in; credit, dispense_*, change_*, status pulses out.
module credit_accumulator
    import vending_pkg::*;
#(
    parameter int PRICE0     = 15,
    parameter int PRICE1     = 25,
    parameter int PRICE2     = 40,
    parameter int PRICE3     = 60,
    parameter int MAX_CREDIT = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          coin_pulse,
    input  logic                select_pulse,
    input  logic [1:0]          product_id,
    input  logic                cancel_pulse,
    input  logic                dispense_ready,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense_valid,
    output logic [1:0]          dispense_id,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                coin_reject,
    output logic                insufficient
);

    localparam logic [CREDIT_W:0] MAX9 = 9'(MAX_CREDIT);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [1:0]          id_q, id_d;
    logic                reject_q, reject_d;
    logic                insuff_q, insuff_d;

    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W:0]   add9;
    logic [CREDIT_W:0]   sub9;
    logic                coin_any;

    price_table #(
        .PRICE0(PRICE0),
        .PRICE1(PRICE1),
        .PRICE2(PRICE2),
        .PRICE3(PRICE3)
    ) u_price (
        .product_id(product_id),
        .price     (price)
    );

    assign coin_any = |coin_pulse;
    assign add9     = {1'b0, credit_q} + coin_sum(coin_pulse);
    assign sub9     = {1'b0, credit_q} - {1'b0, price};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            id_q     <= '0;
            reject_q <= 1'b0;
            insuff_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            id_q     <= id_d;
            reject_q <= reject_d;
            insuff_q <= insuff_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        id_d     = id_q;
        reject_d = 1'b0;
        insuff_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cancel_pulse) begin
                    // Coins arriving alongside a command are bounced.
                    reject_d = coin_any;
                    if (credit_q != '0) state_d = CHANGE;
                end else if (select_pulse) begin
                    reject_d = coin_any;
                    if ({1'b0, credit_q} >= {1'b0, price}) begin
                        credit_d = sub9[CREDIT_W-1:0];
                        id_d     = product_id;
                        state_d  = DISPENSE;
                    end else begin
                        insuff_d = 1'b1;
                    end
                end else if (coin_any) begin
                    if (add9 > MAX9) reject_d = 1'b1;
                    else credit_d = add9[CREDIT_W-1:0];
                end
            end
            DISPENSE: begin
                reject_d = coin_any;
                if (dispense_ready)
                    state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = coin_any;
                if (change_ready) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credit         = credit_q;
        dispense_valid = (state_q == DISPENSE);
        dispense_id    = id_q;
        change_valid   = (state_q == CHANGE);
        change_amount  = (state_q == CHANGE) ? credit_q : '0;
        coin_reject    = reject_q;
        insufficient   = insuff_q;
    end

endmodule

// File: tb/tb_credit_accumulator.sv
// Directed bench for credit_accumulator.
// Drives pulses just after a rising edge, checks 1 ns after the next.
module tb_credit_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] coin_pulse = '0;
    logic       select_pulse = 1'b0;
    logic [1:0] product_id = '0;
    logic       cancel_pulse = 1'b0;
    logic       dispense_ready = 1'b0;
    logic       change_ready = 1'b0;
    logic [7:0] credit;
    logic       dispense_valid;
    logic [1:0] dispense_id;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       coin_reject;
    logic       insufficient;

    int n_run = 0;
    int n_fail = 0;

    credit_accumulator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_pulse    (coin_pulse),
        .select_pulse  (select_pulse),
        .product_id    (product_id),
        .cancel_pulse  (cancel_pulse),
        .dispense_ready(dispense_ready),
        .change_ready  (change_ready),
        .credit        (credit),
        .dispense_valid(dispense_valid),
        .dispense_id   (dispense_id),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .coin_reject   (coin_reject),
        .insufficient  (insufficient)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then drop all one-cycle pulses.
    task automatic step();
        @(posedge clk);
        #1;
        coin_pulse     = '0;
        select_pulse   = 1'b0;
        cancel_pulse   = 1'b0;
        dispense_ready = 1'b0;
        change_ready   = 1'b0;
    endtask

    task automatic coin(input logic [3:0] c);
        coin_pulse = c;
        step();
    endtask

    initial begin
        #12;
        check("rst_credit", credit, 0);
        check("rst_dv", dispense_valid, 0);
        check("rst_cv", change_valid, 0);
        check("rst_rej", coin_reject, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // three 10-unit coins
        coin(4'b1000); check("c10", credit, 10);
        coin(4'b1000); check("c20", credit, 20);
        coin(4'b1000); check("c30", credit, 30);

        // buy product 1 (25) from 30
        select_pulse = 1'b1; product_id = 2'd1; step();
        check("b1_dv", dispense_valid, 1);
        check("b1_id", dispense_id, 1);
        check("b1_credit", credit, 5);
        step();
        check("b1_hold_dv", dispense_valid, 1);
        dispense_ready = 1'b1; step();
        check("b1_dv_off", dispense_valid, 0);
        check("b1_cv", change_valid, 1);
        check("b1_amt", change_amount, 5);
        change_ready = 1'b1; step();
        check("b1_cv_off", change_valid, 0);
        check("b1_zero", credit, 0);

        // cancel with zero credit is ignored
        cancel_pulse = 1'b1; step();
        check("cz_cv", change_valid, 0);

        // insufficient credit for product 0
        coin(4'b1000);
        select_pulse = 1'b1; product_id = 2'd0; step();
        check("ins_pulse", insufficient, 1);
        check("ins_credit", credit, 10);
        check("ins_dv", dispense_valid, 0);
        step();
        check("ins_once", insufficient, 0);

        // 10 + 10*18 + 5 = 195
        for (int i = 0; i < 10; i++) coin(4'b1111);
        coin(4'b0100);
        check("c195", credit, 195);
        coin(4'b1100);
        check("ovf_rej", coin_reject, 1);
        check("ovf_credit", credit, 195);
        coin(4'b0100);
        check("c200", credit, 200);
        check("c200_rej", coin_reject, 0);

        // buy product 3 (60), coin during DISPENSE bounced
        select_pulse = 1'b1; product_id = 2'd3; step();
        check("b3_credit", credit, 140);
        check("b3_id", dispense_id, 3);
        coin(4'b1000);
        check("dsp_rej", coin_reject, 1);
        check("dsp_credit", credit, 140);
        check("dsp_dv", dispense_valid, 1);
        dispense_ready = 1'b1; step();
        check("b3_amt", change_amount, 140);
        change_ready = 1'b1; step();
        check("b3_zero", credit, 0);

        // select+cancel together: cancel wins
        for (int i = 0; i < 4; i++) coin(4'b1000);
        check("c40", credit, 40);
        select_pulse = 1'b1; cancel_pulse = 1'b1; product_id = 2'd2; step();
        check("sc_cv", change_valid, 1);
        check("sc_amt", change_amount, 40);
        check("sc_dv", dispense_valid, 0);
        change_ready = 1'b1; step();
        check("sc_zero", credit, 0);

        // async reset mid-DISPENSE
        for (int i = 0; i < 3; i++) coin(4'b1000);
        select_pulse = 1'b1; product_id = 2'd0; step();
        check("pre_rst_dv", dispense_valid, 1);
        check("pre_rst_credit", credit, 15);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_credit", credit, 0);
        check("ar_dv", dispense_valid, 0);
        check("ar_id", dispense_id, 0);
        check("ar_cv", change_valid, 0);
        check("ar_amt", change_amount, 0);
        check("ar_rej", coin_reject, 0);
        check("ar_ins", insufficient, 0);
        @(negedge clk);
        rst_n = 1'b1;
        coin(4'b0010);
        check("post_rst", credit, 2);
        check("post_dv", dispense_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
